// File: rtl/chirp_capture_ctrl.sv
// Per-chirp capture sequencer: settle-discard, pick-one decimation, NSAMP-word framing over valid/ready.
// Optional CAPTURE_HDR_EN prefixes each frame with a frame-counter header word.
module chirp_capture_ctrl #(
    parameter int unsigned OW     = 14,
    parameter int unsigned M      = 20,
    parameter int unsigned MW     = $clog2(M),
    parameter int unsigned SETTLE = 8,
    parameter int unsigned NSAMP  = 1024,
    parameter int unsigned NW     = $clog2(NSAMP)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          arm_i,
    input  logic          start_i,
    input  logic [OW-1:0] data_i,
    input  logic          clr_i,
    output logic [OW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o,
    output logic          busy_o,
    output logic          ovf_o
);

    localparam int unsigned SW = $clog2(SETTLE + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [MW-1:0] dcnt_q, dcnt_d;
    logic [SW-1:0] stl_q, stl_d;
    logic [NW-1:0] scnt_q, scnt_d;
    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
`ifdef CAPTURE_HDR_EN
    logic [OW-1:0] frm_q, frm_d;
`endif

    logic tick, accept, can_load, final_smp;

    assign tick      = (dcnt_q == MW'(M - 1));
    assign accept    = valid_q && ready_i;
    assign can_load  = !valid_q || accept;
    assign final_smp = (scnt_q == NW'(NSAMP - 1));

    // Next-state and output-register logic
    always_comb begin
        state_d = state_q;
        dcnt_d  = tick ? '0 : dcnt_q + MW'(1);
        stl_d   = stl_q;
        scnt_d  = scnt_q;
        data_d  = data_q;
        valid_d = accept ? 1'b0 : valid_q;
        last_d  = accept ? 1'b0 : last_q;
        ovf_d   = clr_i ? 1'b0 : ovf_q;
`ifdef CAPTURE_HDR_EN
        frm_d   = frm_q;
`endif
        case (state_q)
            S_IDLE: begin
                dcnt_d = '0;
                if (start_i && arm_i) begin
                    state_d = S_SETTLE;
                    stl_d   = '0;
                end
            end
            S_SETTLE: begin
                if (tick) begin
                    if (stl_q == SW'(SETTLE - 1)) begin
                        state_d = S_CAPTURE;
                        scnt_d  = '0;
`ifdef CAPTURE_HDR_EN
                        data_d  = frm_q;
                        valid_d = 1'b1;
                        last_d  = 1'b0;
`endif
                    end else begin
                        stl_d = stl_q + SW'(1);
                    end
                end
            end
            S_CAPTURE: begin
                if (tick) begin
                    if (can_load) begin
                        data_d  = data_i;
                        valid_d = 1'b1;
                        last_d  = final_smp;
                    end else begin
                        // Drop; still mark frame end on the held word
                        ovf_d = 1'b1;
                        if (final_smp) begin
                            last_d = 1'b1;
                        end
                    end
                    if (final_smp) begin
                        state_d = S_FLUSH;
                    end else begin
                        scnt_d = scnt_q + NW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (can_load) begin
                    state_d = S_IDLE;
`ifdef CAPTURE_HDR_EN
                    frm_d   = frm_q + OW'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            stl_q   <= '0;
            scnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef CAPTURE_HDR_EN
            frm_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            stl_q   <= stl_d;
            scnt_q  <= scnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
`ifdef CAPTURE_HDR_EN
            frm_q   <= frm_d;
`endif
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign ovf_o   = ovf_q;

endmodule
